// File: rtl/bcd_byte_converter_pkg.sv
// Shared types and constants for the sequential BCD-to-byte converter.
// Widths are fixed: three BCD digits in, one byte out, ten shift iterations.
package bcd_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int          BCD_DIGITS = 3;
    localparam int          BIN_ITER   = 10;
    localparam int          BCD_W      = 4 * BCD_DIGITS;
    localparam int          WORK_W     = BCD_W + BIN_ITER;
    localparam logic [7:0]  BYTE_MAX   = 8'd255;
    localparam logic [3:0]  DIGIT_MAX  = 4'd9;
    localparam logic [3:0]  LAST_ITER  = 4'(BIN_ITER - 1);

    function automatic logic bcd_legal(input logic [BCD_W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < BCD_DIGITS; i++)
            if (v[4*i +: 4] > DIGIT_MAX) ok = 1'b0;
        return ok;
    endfunction
endpackage

// File: rtl/bcd_byte_converter_if.sv
// Request/response bundle of the converter: start + BCD word in, status + byte out.
interface bcd_byte_converter_if;
    import bcd_pkg::*;

    logic             start;
    logic [BCD_W-1:0] bcd_in;
    logic             busy;
    logic             done;
    logic [7:0]       byte_out;
    logic             ovf;
    logic             err;

    modport master (output start, bcd_in, input busy, done, byte_out, ovf, err);
    modport slave  (input start, bcd_in, output busy, done, byte_out, ovf, err);
endinterface

// File: rtl/bcd_byte_converter_digit_adjust.sv
// Reverse double-dabble correction for one BCD digit after a right shift.
module bcd_digit_adjust (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd8) ? din - 4'd3 : din;
endmodule

// File: rtl/bcd_byte_converter.sv
// Sequential BCD-to-binary converter, one shift/subtract-3 step per clock,
// with saturation on values above 255 and rejection of illegal digits.
module bcd_byte_converter
    import bcd_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    bcd_byte_converter_if.slave bus
);
    state_t            state;
    logic [WORK_W-1:0] work;
    logic [WORK_W-1:0] shifted;
    logic [WORK_W-1:0] work_next;
    logic [3:0]        cnt;
    logic [BIN_ITER-1:0] value;

    assign shifted = {1'b0, work[WORK_W-1:1]};
    assign work_next[BIN_ITER-1:0] = shifted[BIN_ITER-1:0];

    for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_adj
        bcd_digit_adjust u_adj (
            .din  (shifted[BIN_ITER + 4*d +: 4]),
            .dout (work_next[BIN_ITER + 4*d +: 4])
        );
    end

    assign value = work_next[BIN_ITER-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            work         <= '0;
            cnt          <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.byte_out <= '0;
            bus.ovf      <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        if (bcd_legal(bus.bcd_in)) begin
                            work     <= {bus.bcd_in, {BIN_ITER{1'b0}}};
                            cnt      <= '0;
                            bus.busy <= 1'b1;
                            state    <= SHIFT;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    work <= work_next;
                    cnt  <= cnt + 4'd1;
                    if (cnt == LAST_ITER) begin
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.err  <= 1'b0;
                        if (value > {2'b00, BYTE_MAX}) begin
                            bus.byte_out <= BYTE_MAX;
                            bus.ovf      <= 1'b1;
                        end else begin
                            bus.byte_out <= value[7:0];
                            bus.ovf      <= 1'b0;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Entered with done low only on the illegal-digit path:
                    // raise the error result one cycle after the accept.
                    if (bus.done) begin
                        bus.done <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        bus.done     <= 1'b1;
                        bus.err      <= 1'b1;
                        bus.ovf      <= 1'b0;
                        bus.byte_out <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
